math_csr_seq: RTL and testbench

//  Sequencer for the CSR-mapped math engine. Watches the MATH_CTRL/OPA/OPB/OPC CSR taps.
//  On START it latches the operands and runs an iterative 24-bit unsigned MULU, MAC or DIVU.

---
 rtl/math_csr_seq_if.sv | 22 ++
 rtl/math_csr_seq.sv | 199 +++++++++++++++++++
 tb/tb_math_csr_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/math_csr_seq_if.sv
// Auxiliary CSR write port of the math sequencer, together with the snooped CPU write
// strobe that it must yield to.
interface math_csr_seq_if #(
  parameter int DW = 24,
  parameter int AW = 8
);
  logic          ow_w2_enable;
  logic [AW-1:0] ow_w2_addr;
  logic [DW-1:0] ow_w2_data;
  logic          iw_cpu_we;
  logic [AW-1:0] iw_cpu_waddr;

  modport master (
    output ow_w2_enable, ow_w2_addr, ow_w2_data,
    input  iw_cpu_we, iw_cpu_waddr
  );

  modport slave (
    input  ow_w2_enable, ow_w2_addr, ow_w2_data,
    output iw_cpu_we, iw_cpu_waddr
  );
endinterface

// File: rtl/math_csr_seq.sv
// Math engine sequencer: latches CSR operands on START, runs an iterative 24-step
// MULU/MAC/DIVU and writes results and status back through the auxiliary CSR port.
module math_csr_seq #(
  parameter int            DW        = 24,
  parameter int            AW        = 8,
  parameter logic [AW-1:0] IDX_CTRL  = 8'h40,
  parameter logic [AW-1:0] IDX_RESLO = 8'h44,
  parameter logic [AW-1:0] IDX_RESHI = 8'h45,
  parameter logic [AW-1:0] IDX_STAT  = 8'h46
) (
  input  logic           iw_clk,
  input  logic           iw_rst,
  input  logic [DW-1:0]  iw_math_ctrl,
  input  logic [DW-1:0]  iw_math_opa,
  input  logic [DW-1:0]  iw_math_opb,
  input  logic [DW-1:0]  iw_math_opc,
  math_csr_seq_if.master csr_bus,
  output logic           ow_busy,
  output logic           ow_done
);

  localparam int            CW        = $clog2(DW);
  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);
  localparam logic [2:0]    OP_MAC    = 3'd1;
  localparam logic [2:0]    OP_DIVU   = 3'd2;
  localparam logic [DW-1:0] STAT_BUSY = DW'(24'h000001);
  localparam logic [DW-1:0] STAT_DONE = DW'(24'h000002);
  localparam logic [DW-1:0] STAT_DZ   = DW'(24'h000006);
  localparam logic [DW-1:0] STAT_BAD  = DW'(24'h00000A);
  localparam logic [DW-1:0] STAT_ABT  = DW'(24'h000012);

  typedef enum logic [3:0] {
    S_IDLE, S_ACK, S_ST_BUSY, S_RUN, S_WR_LO, S_WR_HI, S_WR_ST,
    S_ST_DZ, S_ST_BAD, S_AB_ACK, S_AB_ST
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   iter_cnt;
  logic [2:0]      op_q;
  logic [DW-1:0]   opa_q, opb_q, opc_q;
  logic [DW-1:0]   acc_hi, acc_lo;
  logic [2*DW-1:0] acc_nxt;
  logic            wr_req, done_req, collide;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;

  // Shift-add multiply step: lo holds the unconsumed multiplier bits, hi the partial product.
  function automatic logic [2*DW-1:0] mul_step(input logic [DW-1:0] hi,
                                               input logic [DW-1:0] lo,
                                               input logic [DW-1:0] a);
    logic [DW:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, a} : {(DW+1){1'b0}});
    return {sum, lo[DW-1:1]};
  endfunction

  // Restoring divide step: hi is the running remainder, lo shifts dividend out and quotient in.
  function automatic logic [2*DW-1:0] div_step(input logic [DW-1:0] hi,
                                               input logic [DW-1:0] lo,
                                               input logic [DW-1:0] b);
    logic [DW:0] rs;
    rs = {hi, lo[DW-1]};
    if (rs >= {1'b0, b}) begin
      rs = rs - {1'b0, b};
      return {rs[DW-1:0], lo[DW-2:0], 1'b1};
    end
    return {rs[DW-1:0], lo[DW-2:0], 1'b0};
  endfunction

  function automatic logic [2*DW-1:0] mac_add(input logic [2*DW-1:0] p,
                                              input logic [DW-1:0]   c);
    return p + {{DW{1'b0}}, c};
  endfunction

  always_comb begin
    acc_nxt = '0;
    if (op_q == OP_DIVU) acc_nxt = div_step(acc_hi, acc_lo, opb_q);
    else                 acc_nxt = mul_step(acc_hi, acc_lo, opa_q);
    if (op_q == OP_MAC && iter_cnt == LAST_ITER) acc_nxt = mac_add(acc_nxt, opc_q);
  end

  always_comb begin
    state_d  = state_q;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    done_req = 1'b0;
    case (state_q)
      S_IDLE:    if (iw_math_ctrl[0]) state_d = S_ACK;
      S_ACK: begin
        wr_req  = 1'b1;
        wr_addr = IDX_CTRL;
        wr_data = iw_math_ctrl & ~DW'(1);
        if (op_q > OP_DIVU)                       state_d = S_ST_BAD;
        else if (op_q == OP_DIVU && opb_q == '0)  state_d = S_ST_DZ;
        else                                      state_d = S_ST_BUSY;
      end
      S_ST_BUSY: begin
        wr_req  = 1'b1;
        wr_addr = IDX_STAT;
        wr_data = STAT_BUSY;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (iw_math_ctrl[4])             state_d = S_AB_ACK;
        else if (iter_cnt == LAST_ITER)  state_d = S_WR_LO;
      end
      S_ST_DZ:   state_d = S_WR_LO;
      S_WR_LO: begin
        wr_req  = 1'b1;
        wr_addr = IDX_RESLO;
        wr_data = acc_lo;
        state_d = S_WR_HI;
      end
      S_WR_HI: begin
        wr_req  = 1'b1;
        wr_addr = IDX_RESHI;
        wr_data = acc_hi;
        state_d = S_WR_ST;
      end
      S_WR_ST: begin
        wr_req   = 1'b1;
        wr_addr  = IDX_STAT;
        wr_data  = (op_q == OP_DIVU && opb_q == '0) ? STAT_DZ : STAT_DONE;
        done_req = 1'b1;
        state_d  = S_IDLE;
      end
      S_ST_BAD: begin
        wr_req   = 1'b1;
        wr_addr  = IDX_STAT;
        wr_data  = STAT_BAD;
        done_req = 1'b1;
        state_d  = S_IDLE;
      end
      S_AB_ACK: begin
        wr_req  = 1'b1;
        wr_addr = IDX_CTRL;
        wr_data = '0;
        state_d = S_AB_ST;
      end
      S_AB_ST: begin
        wr_req   = 1'b1;
        wr_addr  = IDX_STAT;
        wr_data  = STAT_ABT;
        done_req = 1'b1;
        state_d  = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase

    // The CPU owns the CSR on a same-address clash; stall and retry next cycle.
    collide = wr_req && csr_bus.iw_cpu_we && (csr_bus.iw_cpu_waddr == wr_addr);
    if (collide) begin
      state_d  = state_q;
      wr_req   = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      done_req = 1'b0;
    end

    csr_bus.ow_w2_enable = wr_req;
    csr_bus.ow_w2_addr   = wr_addr;
    csr_bus.ow_w2_data   = wr_data;
    ow_done              = done_req;
    ow_busy              = (state_q != S_IDLE);
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q  <= S_IDLE;
      iter_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ST_BUSY)  iter_cnt <= '0;
      else if (state_q == S_RUN) iter_cnt <= iter_cnt + 1'b1;
    end
  end

  always_ff @(posedge iw_clk) begin
    if (state_q == S_IDLE && iw_math_ctrl[0]) begin
      op_q  <= iw_math_ctrl[3:1];
      opa_q <= iw_math_opa;
      opb_q <= iw_math_opb;
      opc_q <= iw_math_opc;
    end
    case (state_q)
      S_ST_BUSY: begin
        acc_hi <= '0;
        acc_lo <= (op_q == OP_DIVU) ? opa_q : opb_q;
      end
      S_RUN:     {acc_hi, acc_lo} <= acc_nxt;
      S_ST_DZ: begin
        acc_hi <= opa_q;
        acc_lo <= '1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_math_csr_seq.sv
// Bench for math_csr_seq: a behavioural CSR file feeds the taps and absorbs both writers.
module tb_math_csr_seq;
  localparam int DW = 24;
  localparam int AW = 8;
  localparam logic [7:0] I_CTRL = 8'h40, I_OPA = 8'h41, I_OPB = 8'h42, I_OPC = 8'h43;
  localparam logic [7:0] I_LO = 8'h44, I_HI = 8'h45, I_ST = 8'h46;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [23:0] csr [256];
  logic        csr_clr;
  logic [23:0] cpu_wdata;
  logic [23:0] math_ctrl, math_opa, math_opb, math_opc;
  logic        busy, done;
  int          cyc = 0;
  int          w2_cnt = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  math_csr_seq_if #(.DW(DW), .AW(AW)) bus ();

  math_csr_seq #(
    .DW(DW), .AW(AW), .IDX_CTRL(I_CTRL), .IDX_RESLO(I_LO), .IDX_RESHI(I_HI), .IDX_STAT(I_ST)
  ) dut (
    .iw_clk       (clk),
    .iw_rst       (rst),
    .iw_math_ctrl (math_ctrl),
    .iw_math_opa  (math_opa),
    .iw_math_opb  (math_opb),
    .iw_math_opc  (math_opc),
    .csr_bus      (bus),
    .ow_busy      (busy),
    .ow_done      (done)
  );

  assign math_ctrl = csr[I_CTRL];
  assign math_opa  = csr[I_OPA];
  assign math_opb  = csr[I_OPB];
  assign math_opc  = csr[I_OPC];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.ow_w2_enable) w2_cnt <= w2_cnt + 1;

  // CPU write is issued after the aux write so it wins any same-address race.
  always @(posedge clk) begin
    if (csr_clr) begin
      for (int i = 0; i < 256; i++) csr[i] <= '0;
    end else begin
      if (bus.ow_w2_enable) csr[bus.ow_w2_addr] <= bus.ow_w2_data;
      if (bus.iw_cpu_we)    csr[bus.iw_cpu_waddr] <= cpu_wdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [23:0] data);
    @(posedge clk); #1;
    bus.iw_cpu_we    = 1'b1;
    bus.iw_cpu_waddr = addr;
    cpu_wdata        = data;
    @(posedge clk); #1;
    bus.iw_cpu_we    = 1'b0;
    bus.iw_cpu_waddr = '0;
    cpu_wdata        = '0;
  endtask

  // Returns in cycle T, the first cycle in which START is visible on the tap.
  task automatic run_op(input logic [2:0] op, input logic [23:0] a, input logic [23:0] b,
                        input logic [23:0] c, output int t0);
    cpu_write(I_LO, 24'hA5A5A5);
    cpu_write(I_HI, 24'hA5A5A5);
    cpu_write(I_OPA, a);
    cpu_write(I_OPB, b);
    cpu_write(I_OPC, c);
    cpu_write(I_CTRL, {20'd0, op, 1'b1});
    t0 = cyc;
  endtask

  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [23:0] a, b, c;
    logic [23:0] lo, hi, st;
    int          lat;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int t0, lat, w_snap;

    tbl[0] = '{3'd0, 24'h001234, 24'h000100, 24'h000000, 24'h123400, 24'h000000, 24'h000002, 29};
    tbl[1] = '{3'd1, 24'hFFFFFF, 24'hFFFFFF, 24'h000005, 24'h000006, 24'hFFFFFE, 24'h000002, 29};
    tbl[2] = '{3'd2, 24'd100,    24'd7,      24'h000000, 24'd14,     24'd2,      24'h000002, 29};
    tbl[3] = '{3'd2, 24'd100,    24'd0,      24'h000000, 24'hFFFFFF, 24'd100,    24'h000006, 5};
    tbl[4] = '{3'd0, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000001, 24'hFFFFFE, 24'h000002, 29};
    tbl[5] = '{3'd1, 24'd3,      24'd4,      24'hFFFFFF, 24'h00000B, 24'h000001, 24'h000002, 29};
    tbl[6] = '{3'd2, 24'hFFFFFF, 24'd1,      24'h000000, 24'hFFFFFF, 24'h000000, 24'h000002, 29};
    tbl[7] = '{3'd2, 24'd5,      24'd9,      24'h000000, 24'h000000, 24'd5,      24'h000002, 29};
    tbl[8] = '{3'd5, 24'd7,      24'd3,      24'h000000, 24'hA5A5A5, 24'hA5A5A5, 24'h00000A, 2};

    rst = 1'b1;
    csr_clr = 1'b1;
    bus.iw_cpu_we = 1'b0;
    bus.iw_cpu_waddr = '0;
    cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_w2_enable", {31'd0, bus.ow_w2_enable}, 0);
    chk("rst_w2_addr", {24'd0, bus.ow_w2_addr}, 0);
    chk("rst_w2_data", {8'd0, bus.ow_w2_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    csr_clr = 1'b0;

    for (int v = 0; v < 9; v++) begin
      run_op(tbl[v].op, tbl[v].a, tbl[v].b, tbl[v].c, t0);
      @(negedge clk);
      chk($sformatf("v%0d_busy_T", v), {31'd0, busy}, 0);
      @(negedge clk);
      chk($sformatf("v%0d_busy_T1", v), {31'd0, busy}, 1);
      wait_done(t0, lat);
      chk($sformatf("v%0d_done_latency", v), lat, tbl[v].lat);
      @(posedge clk); #1;
      chk($sformatf("v%0d_reslo", v), {8'd0, csr[I_LO]}, {8'd0, tbl[v].lo});
      chk($sformatf("v%0d_reshi", v), {8'd0, csr[I_HI]}, {8'd0, tbl[v].hi});
      chk($sformatf("v%0d_status", v), {8'd0, csr[I_ST]}, {8'd0, tbl[v].st});
      chk($sformatf("v%0d_ctrl", v), {8'd0, csr[I_CTRL]}, {28'd0, tbl[v].op, 1'b0});
      chk($sformatf("v%0d_busy_after", v), {31'd0, busy}, 0);
    end

    // CPU hits STATUS in the ST_BUSY cycle: aux write must stall one cycle.
    run_op(3'd0, 24'h001234, 24'h000100, 24'd0, t0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.iw_cpu_we = 1'b1;
    bus.iw_cpu_waddr = I_ST;
    cpu_wdata = 24'h000055;
    @(negedge clk);
    chk("coll_w2_held", {31'd0, bus.ow_w2_enable}, 0);
    chk("coll_addr_zero", {24'd0, bus.ow_w2_addr}, 0);
    @(posedge clk); #1;
    bus.iw_cpu_we = 1'b0;
    bus.iw_cpu_waddr = '0;
    cpu_wdata = '0;
    @(negedge clk);
    chk("coll_cpu_landed", {8'd0, csr[I_ST]}, 32'h55);
    chk("coll_retry_en", {31'd0, bus.ow_w2_enable}, 1);
    chk("coll_retry_addr", {24'd0, bus.ow_w2_addr}, {24'd0, I_ST});
    chk("coll_retry_data", {8'd0, bus.ow_w2_data}, 1);
    wait_done(t0, lat);
    chk("coll_done_latency", lat, 30);
    @(posedge clk); #1;
    chk("coll_reslo", {8'd0, csr[I_LO]}, 32'h123400);
    chk("coll_status", {8'd0, csr[I_ST]}, 32'h2);

    // ABORT becomes visible on the tap at T+10 while in RUN.
    run_op(3'd0, 24'h001234, 24'h000100, 24'd0, t0);
    repeat (8) @(posedge clk);
    cpu_write(I_CTRL, 24'h000010);
    wait_done(t0, lat);
    chk("abort_done_latency", lat, 12);
    @(posedge clk); #1;
    chk("abort_ctrl", {8'd0, csr[I_CTRL]}, 0);
    chk("abort_status", {8'd0, csr[I_ST]}, 32'h12);
    chk("abort_reslo", {8'd0, csr[I_LO]}, 32'hA5A5A5);
    chk("abort_reshi", {8'd0, csr[I_HI]}, 32'hA5A5A5);

    // One-cycle reset in the middle of RUN.
    run_op(3'd0, 24'h001234, 24'h000100, 24'd0, t0);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cycle", cyc - t0, 16);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_w2_en", {31'd0, bus.ow_w2_enable}, 0);
    chk("mid_rst_w2_addr", {24'd0, bus.ow_w2_addr}, 0);
    chk("mid_rst_w2_data", {8'd0, bus.ow_w2_data}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    w_snap = w2_cnt;
    repeat (40) @(negedge clk);
    chk("mid_rst_no_writes", w2_cnt - w_snap, 0);
    chk("mid_rst_status", {8'd0, csr[I_ST]}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
